wb_pwm_fader: RTL
=================

# wb_pwm_fader

Wishbone-controlled fade scheduler for `wb_pwm`. Software writes a target duty per channel over a slave port. The block steps each channel's current duty toward its target by ±1 on every fade tick, and writes the new values into `wb_pwm` through a Wishbone B4 pipelined master port. It sits between the CPU interconnect and one `wb_pwm` instance and is the only master of that instance.

## Interface
- `CHANNEL_NUM`, 3: number of PWM channels managed; must be ≤ 14.
- `TICK_DIV`, 1024: clock cycles per fade step; ≥ 2.
- `wb_clk_i` in 1: clock.
- `wb_rst_ni` in 1: reset, asynchronous assert, active-low.
- `s_wb_cyc_i`, `s_wb_stb_i`, `s_wb_we_i` in 1 each: slave request.
- `s_wb_adr_i` in 4: slave register address.
- `s_wb_dat_i` in 32: slave write data.
- `s_wb_dat_o` out 32: slave read data.
- `s_wb_ack_o` out 1: slave acknowledge.
- `s_wb_stall_o` out 1: tied 0.
- `m_wb_cyc_o`, `m_wb_stb_o`, `m_wb_we_o` out 1 each: master request; `m_wb_we_o` = `m_wb_stb_o`.
- `m_wb_adr_o` out 4: PWM channel index.
- `m_wb_dat_o` out 32: duty value in [7:0]; [31:8] = 0.
- `m_wb_stall_i`, `m_wb_ack_i` in 1 each: master handshake.

## Operation
- **Per-channel registers:**
  - `target[ch]`, 8 bit, reset 0.
  - `current[ch]`, 8 bit, reset 0.
- **Global register:** `enable`, 1 bit, reset 0.
- **Slave map:**
  - Address ch < `CHANNEL_NUM`:
    - Write sets `target[ch]` = dat[7:0].
    - Read returns {23'b0, busy_ch, `current[ch]`}, where busy_ch = (`current` ≠ `target`).
  - Address 0xF:
    - Write bit0 sets `enable`.
    - Read returns {31'b0, `enable`}.
  - Other addresses: writes are ignored and reads return 0.
- **Tick counter:**
  - Counts 0..`TICK_DIV`-1 while `enable` = 1.
  - Wrapping to 0 sets `pending`.
  - When `enable` = 0, the counter is held at 0 and `pending` is not set.
  - Ticks arriving while `pending` is already set coalesce into a single pending step.
- **Scheduler FSM:** INIT, IDLE, SCAN, REQ, WAIT.
  - **INIT (entered out of reset):** writes `current[ch]` (0) to every channel 0..N-1 in order, then goes to IDLE. This synchronises `wb_pwm` regardless of its own reset state.
  - **IDLE:** if `pending`, clear `pending`, set ch=0, go to SCAN.
  - **SCAN:**
    - If `current[ch]` < `target[ch]`, increment `current[ch]` and go to REQ.
    - If `current[ch]` > `target[ch]`, decrement `current[ch]` and go to REQ.
    - If equal, advance ch. After the last channel, go to IDLE.
  - **REQ:**
    - Drive `m_wb_cyc_o` = `m_wb_stb_o` = 1, `m_wb_adr_o` = ch, `m_wb_dat_o` = updated `current[ch]`.
    - Hold all master outputs stable while `m_wb_stall_i` = 1.
    - On a cycle with `m_wb_stall_i` = 0, the request is accepted; go to WAIT.
  - **WAIT:**
    - `m_wb_stb_o` = 0, `m_wb_cyc_o` = 1.
    - On `m_wb_ack_i`, drop `m_wb_cyc_o`, advance ch, and return to SCAN (INIT uses the same REQ/WAIT path).
  - `m_wb_ack_i` outside WAIT is ignored.
- **Arithmetic:** steps are exactly ±1. `current` never overshoots `target` and never wraps past 0x00 or 0xFF.
- **Target changes:** a `target` write during a pass is used when SCAN next reaches that channel. Only one step per channel per pass.
- **Disabling:** clearing `enable` mid-pass lets the pass finish; no new passes start.
- **Reset mid-transaction:** all outputs drop asynchronously; after release, the FSM restarts in INIT.

## Timing
- **Reset values:**
  - All master outputs 0.
  - `s_wb_ack_o` = 0, `s_wb_dat_o` = 0.
  - All registers 0, FSM in INIT.
- **Slave:**
  - `s_wb_ack_o` is registered, 1 cycle after `cyc & stb`.
  - `s_wb_dat_o` is valid in the same cycle as the ack.
  - A write takes effect on the accepting edge.
- **Master, one write with no stall:**
  - 1 SCAN cycle, 1 REQ cycle, and ≥1 WAIT cycle.
  - With a 1-cycle registered ack, that is 3 cycles per changed channel.
- An unchanged channel costs 1 SCAN cycle.
- A full pass over N channels with no changes takes N cycles.
- **Simultaneous events:**
  - A slave write to `target[ch]` in the same cycle SCAN samples `target[ch]` uses the old value.
  - The new value is used on the next pass.

## Test plan
- Reset release with `m_wb_ack_i` returned 1 cycle after `stb` → 3 master writes, adr 0,1,2 with dat 0, then `m_wb_cyc_o` = 0.
- `TICK_DIV`=4, enable=1, `target[1]`=3 → three passes, each writing adr 1 with dat 1, 2, 3 in turn; then no further master traffic; read adr 1 returns 0x003.
- `target[0]`=0xFF, then after 5 steps write `target[0]`=0x02 → values climb to 5, then descend 4, 3, 2 and stop; `current[0]` never exceeds 5.
- `m_wb_stall_i` held high for 4 cycles during REQ → adr/dat/stb stable for all stalled cycles; exactly one write is accepted.
- Ticks every 2 cycles against a slow ack (5 cycles) → passes coalesce; each channel advances at most 1 per pass; no lost or duplicate write per pass.
- Assert `wb_rst_ni` low while in WAIT → `m_wb_cyc_o` = 0 immediately; after release, INIT rewrites 0 to all channels.

Source files
------------

// File: rtl/wb_pwm_fader.sv
// Fade scheduler: steps each channel's PWM duty by +/-1 per fade tick toward a software target, pushing updates to wb_pwm.
// Latency: slave ack 1 cycle after cyc&stb; each changed channel costs SCAN+REQ+WAIT (3 cycles with a 1-cycle ack), unchanged 1 cycle.
// Backpressure: slave never stalls; master holds adr/dat/stb stable while m_wb_stall_i is high and waits for m_wb_ack_i.
module wb_pwm_fader #(
   parameter int CHANNEL_NUM = 3,
   parameter int TICK_DIV    = 1024
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_ni,
   input  logic        s_wb_cyc_i,
   input  logic        s_wb_stb_i,
   input  logic        s_wb_we_i,
   input  logic [3:0]  s_wb_adr_i,
   input  logic [31:0] s_wb_dat_i,
   output logic [31:0] s_wb_dat_o,
   output logic        s_wb_ack_o,
   output logic        s_wb_stall_o,
   output logic        m_wb_cyc_o,
   output logic        m_wb_stb_o,
   output logic        m_wb_we_o,
   output logic [3:0]  m_wb_adr_o,
   output logic [31:0] m_wb_dat_o,
   input  logic        m_wb_stall_i,
   input  logic        m_wb_ack_i
);

   localparam int              CNT_W   = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [3:0]      LAST_CH = 4'(CHANNEL_NUM - 1);

   typedef enum logic [2:0] {INIT, IDLE, SCAN, REQ, WAIT} state_t;

   state_t           state, state_nxt;
   logic [7:0]       target  [CHANNEL_NUM];
   logic [7:0]       current [CHANNEL_NUM];
   logic             enable, pending, init_mode;
   logic [3:0]       ch;
   logic [CNT_W-1:0] tick_cnt;
   logic             tick;
   logic [7:0]       cur_sel, tgt_sel;
   logic [31:0]      rd_dat;
   logic             step_up, step_dn, ch_next, ch_zero, pend_clr, init_done;
   logic             s_acc, s_wr;
   logic             dat_unused;

   assign s_acc        = s_wb_cyc_i & s_wb_stb_i;
   assign s_wr         = s_acc & s_wb_we_i;
   assign s_wb_stall_o = 1'b0;
   assign tick         = enable && (tick_cnt == CNT_MAX);
   assign dat_unused   = ^s_wb_dat_i[31:8];

   // Master outputs come straight from the state register so reset clears them asynchronously
   assign m_wb_stb_o = (state == REQ);
   assign m_wb_cyc_o = (state == REQ) || (state == WAIT);
   assign m_wb_we_o  = m_wb_stb_o;
   assign m_wb_adr_o = m_wb_stb_o ? ch : 4'd0;
   assign m_wb_dat_o = m_wb_stb_o ? {24'd0, cur_sel} : 32'd0;

   // Select the registers of the channel the scheduler is working on
   always_comb begin
      cur_sel = 8'd0;
      tgt_sel = 8'd0;
      for (int i = 0; i < CHANNEL_NUM; i++) begin
         if (ch == 4'(i)) begin
            cur_sel = current[i];
            tgt_sel = target[i];
         end
      end
   end

   // Slave read mux: channel status words and the enable register
   always_comb begin
      rd_dat = 32'd0;
      if (s_wb_adr_i == 4'hF) rd_dat = {31'd0, enable};
      for (int i = 0; i < CHANNEL_NUM; i++) begin
         if (s_wb_adr_i == 4'(i)) rd_dat = {23'd0, current[i] != target[i], current[i]};
      end
   end

   // Scheduler next-state and control strobes; INIT shares the REQ/WAIT path with normal passes
   always_comb begin
      state_nxt = state;
      step_up   = 1'b0;
      step_dn   = 1'b0;
      ch_next   = 1'b0;
      ch_zero   = 1'b0;
      pend_clr  = 1'b0;
      init_done = 1'b0;
      case (state)
         INIT: state_nxt = REQ;
         IDLE: begin
            if (pending) begin
               pend_clr  = 1'b1;
               ch_zero   = 1'b1;
               state_nxt = SCAN;
            end
         end
         SCAN: begin
            if (cur_sel < tgt_sel) begin
               step_up   = 1'b1;
               state_nxt = REQ;
            end else if (cur_sel > tgt_sel) begin
               step_dn   = 1'b1;
               state_nxt = REQ;
            end else if (ch == LAST_CH) begin
               state_nxt = IDLE;
            end else begin
               ch_next = 1'b1;
            end
         end
         REQ: begin
            if (!m_wb_stall_i) state_nxt = WAIT;
         end
         WAIT: begin
            if (m_wb_ack_i) begin
               if (ch == LAST_CH) begin
                  init_done = init_mode;
                  state_nxt = IDLE;
               end else begin
                  ch_next   = 1'b1;
                  state_nxt = init_mode ? INIT : SCAN;
               end
            end
         end
         default: state_nxt = INIT;
      endcase
   end

   // Scheduler state, channel pointer and init-sweep flag
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state     <= INIT;
         ch        <= 4'd0;
         init_mode <= 1'b1;
      end else begin
         state <= state_nxt;
         if (ch_zero)      ch <= 4'd0;
         else if (ch_next) ch <= ch + 4'd1;
         if (init_done) init_mode <= 1'b0;
      end
   end

   // Register file: software targets, enable, and the +/-1 duty steps taken in SCAN
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         enable <= 1'b0;
         for (int i = 0; i < CHANNEL_NUM; i++) begin
            target[i]  <= 8'd0;
            current[i] <= 8'd0;
         end
      end else begin
         if (s_wr && (s_wb_adr_i == 4'hF)) enable <= s_wb_dat_i[0];
         for (int i = 0; i < CHANNEL_NUM; i++) begin
            if (s_wr && (s_wb_adr_i == 4'(i))) target[i] <= s_wb_dat_i[7:0];
            if (ch == 4'(i)) begin
               if (step_up)      current[i] <= current[i] + 8'd1;
               else if (step_dn) current[i] <= current[i] - 8'd1;
            end
         end
      end
   end

   // Fade tick divider; ticks landing on an already pending step merge into it, disable drops any pending step
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         tick_cnt <= '0;
         pending  <= 1'b0;
      end else begin
         if (!enable)   tick_cnt <= '0;
         else if (tick) tick_cnt <= '0;
         else           tick_cnt <= tick_cnt + CNT_ONE;
         if (!enable)       pending <= 1'b0;
         else if (tick)     pending <= 1'b1;
         else if (pend_clr) pending <= 1'b0;
      end
   end

   // Slave response: registered ack with read data valid alongside it
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         s_wb_ack_o <= 1'b0;
         s_wb_dat_o <= 32'd0;
      end else begin
         s_wb_ack_o <= s_acc;
         s_wb_dat_o <= (s_acc && !s_wb_we_i) ? rd_dat : 32'd0;
      end
   end

endmodule
